// File: rtl/round_controller.sv
// Match sequencer for the two-player fighting datapath: gates pad inputs, holds the
// players in reset between rounds, runs the countdown/fight timers and keeps the score.
module round_controller #(
   parameter int COUNTDOWN_CYCLES = 3,
   parameter int ROUND_CYCLES     = 16,
   parameter int ROUNDS_TO_WIN    = 2,
   parameter int MAX_ROUNDS       = 3,
   parameter int CNT_W            = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       right_raw_input,
   input  logic [5:0]       left_raw_input,
   input  logic [1:0]       right_health,
   input  logic [1:0]       left_health,
   output logic [5:0]       right_player_input,
   output logic [5:0]       left_player_input,
   output logic             player_rst_n,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] timer,
   output logic [1:0]       round_num,
   output logic [1:0]       right_wins,
   output logic [1:0]       left_wins,
   output logic             match_over,
   output logic [1:0]       winner
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_COUNTDOWN = 3'd1;
   localparam logic [2:0] S_FIGHT     = 3'd2;
   localparam logic [2:0] S_ROUND_END = 3'd3;
   localparam logic [2:0] S_MATCH_END = 3'd4;

   localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COUNTDOWN_CYCLES - 1);
   localparam logic [CNT_W-1:0] RC_LOAD = CNT_W'(ROUND_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [1:0]       RTW     = 2'(ROUNDS_TO_WIN);
   localparam logic [1:0]       MR      = 2'(MAX_ROUNDS);

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v == 2'd3) ? 2'd3 : v + 2'd1;
   endfunction

   logic [2:0]       next_state;
   logic [CNT_W-1:0] timer_d;
   logic [1:0]       round_num_d, right_wins_d, left_wins_d, winner_d;
   logic [5:0]       right_gated_d, left_gated_d;
   logic             player_rst_n_d, match_over_d;

   logic r_ko, l_ko, timed_out, round_done, right_takes, left_takes, match_done;

   // Round outcome: double KO beats single KO, which beats time-out on health
   always_comb begin
      r_ko        = (right_health == 2'd0);
      l_ko        = (left_health == 2'd0);
      timed_out   = (timer == '0);
      round_done  = (state == S_FIGHT) && (r_ko || l_ko || timed_out);
      right_takes = (l_ko && !r_ko) ||
                    (!r_ko && !l_ko && timed_out && (right_health > left_health));
      left_takes  = (r_ko && !l_ko) ||
                    (!r_ko && !l_ko && timed_out && (left_health > right_health));
      match_done  = (right_wins >= RTW) || (left_wins >= RTW) || (round_num >= MR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= S_IDLE;
         timer              <= '0;
         round_num          <= 2'd0;
         right_wins         <= 2'd0;
         left_wins          <= 2'd0;
         winner             <= 2'd0;
         match_over         <= 1'b0;
         player_rst_n       <= 1'b0;
         right_player_input <= 6'd0;
         left_player_input  <= 6'd0;
      end else begin
         state              <= next_state;
         timer              <= timer_d;
         round_num          <= round_num_d;
         right_wins         <= right_wins_d;
         left_wins          <= left_wins_d;
         winner             <= winner_d;
         match_over         <= match_over_d;
         player_rst_n       <= player_rst_n_d;
         right_player_input <= right_gated_d;
         left_player_input  <= left_gated_d;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      if (start) next_state = S_COUNTDOWN;
         S_COUNTDOWN: if (timed_out) next_state = S_FIGHT;
         S_FIGHT:     if (round_done) next_state = S_ROUND_END;
         S_ROUND_END: next_state = match_done ? S_MATCH_END : S_COUNTDOWN;
         S_MATCH_END: if (start) next_state = S_COUNTDOWN;
         default:     next_state = S_IDLE;
      endcase
   end

   always_comb begin
      timer_d      = timer;
      round_num_d  = round_num;
      right_wins_d = right_wins;
      left_wins_d  = left_wins;
      winner_d     = winner;
      case (state)
         S_IDLE, S_MATCH_END: begin
            if (start) begin
               timer_d      = CD_LOAD;
               round_num_d  = 2'd0;
               right_wins_d = 2'd0;
               left_wins_d  = 2'd0;
               winner_d     = 2'd0;
            end
         end
         S_COUNTDOWN: timer_d = timed_out ? RC_LOAD : timer - CNT_ONE;
         S_FIGHT: begin
            if (round_done) begin
               round_num_d = sat_inc(round_num);
               if (right_takes) right_wins_d = sat_inc(right_wins);
               if (left_takes)  left_wins_d  = sat_inc(left_wins);
            end else begin
               timer_d = timer - CNT_ONE;
            end
         end
         S_ROUND_END: begin
            if (match_done) begin
               if (right_wins > left_wins)      winner_d = 2'b01;
               else if (left_wins > right_wins) winner_d = 2'b10;
               else                             winner_d = 2'b11;
            end else begin
               timer_d = CD_LOAD;
            end
         end
         default: timer_d = '0;
      endcase

      // A restart from MATCH_END still gives the players one cycle of reset
      player_rst_n_d = !((next_state == S_IDLE) || (next_state == S_ROUND_END) ||
                         ((state == S_MATCH_END) && start));
      match_over_d   = (next_state == S_MATCH_END);
      right_gated_d  = (next_state == S_FIGHT) ? right_raw_input : 6'd0;
      left_gated_d   = (next_state == S_FIGHT) ? left_raw_input  : 6'd0;
   end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller at default parameters: countdown, KO rounds,
// time-out and draw rounds, match end/restart and asynchronous abort.
module tb_round_controller;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] right_raw_input, left_raw_input;
   logic [1:0] right_health, left_health;
   logic [5:0] right_player_input, left_player_input;
   logic       player_rst_n;
   logic [2:0] state;
   logic [7:0] timer;
   logic [1:0] round_num, right_wins, left_wins, winner;
   logic       match_over;

   int n_pass  = 0;
   int n_total = 0;

   round_controller dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .right_raw_input(right_raw_input), .left_raw_input(left_raw_input),
      .right_health(right_health), .left_health(left_health),
      .right_player_input(right_player_input), .left_player_input(left_player_input),
      .player_rst_n(player_rst_n), .state(state), .timer(timer),
      .round_num(round_num), .right_wins(right_wins), .left_wins(left_wins),
      .match_over(match_over), .winner(winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0;
      right_raw_input = 6'h00; left_raw_input = 6'h00;
      right_health = 2'd3; left_health = 2'd3;
      step(); step();
      n_total++; if (state !== 3'd0) $display("FAIL rst_state got %0d want 0", state); else n_pass++;
      n_total++; if (timer !== 8'd0) $display("FAIL rst_timer got %0d want 0", timer); else n_pass++;
      n_total++; if (player_rst_n !== 1'b0) $display("FAIL rst_prn got %b want 0", player_rst_n); else n_pass++;
      n_total++; if ({winner, match_over} !== 3'b000) $display("FAIL rst_winner got %b/%b want 00/0", winner, match_over); else n_pass++;
      n_total++; if ({right_wins, left_wins, round_num} !== 6'd0) $display("FAIL rst_scores got %b want 0", {right_wins, left_wins, round_num}); else n_pass++;
      rst_n = 1'b1;
      step();
      n_total++; if (state !== 3'd0) $display("FAIL idle_hold got %0d want 0", state); else n_pass++;
   endtask

   task automatic test_countdown();
      start = 1'b1;
      step();
      start = 1'b0;
      n_total++; if (state !== 3'd1) $display("FAIL cd_state got %0d want 1", state); else n_pass++;
      n_total++; if (timer !== 8'd2) $display("FAIL cd_t2 got %0d want 2", timer); else n_pass++;
      n_total++; if (player_rst_n !== 1'b1) $display("FAIL cd_prn got %b want 1", player_rst_n); else n_pass++;
      right_raw_input = 6'h3F; left_raw_input = 6'h3F;
      step();
      n_total++; if (timer !== 8'd1) $display("FAIL cd_t1 got %0d want 1", timer); else n_pass++;
      n_total++; if (right_player_input !== 6'h00) $display("FAIL cd_gate got %h want 00", right_player_input); else n_pass++;
      step();
      n_total++; if (timer !== 8'd0) $display("FAIL cd_t0 got %0d want 0", timer); else n_pass++;
      right_raw_input = 6'h15; left_raw_input = 6'h2A;
      step();
      n_total++; if (state !== 3'd2) $display("FAIL fight_state got %0d want 2", state); else n_pass++;
      n_total++; if (timer !== 8'd15) $display("FAIL fight_timer got %0d want 15", timer); else n_pass++;
      n_total++; if ({right_player_input, left_player_input} !== {6'h15, 6'h2A}) $display("FAIL fight_gate got %h/%h want 15/2a", right_player_input, left_player_input); else n_pass++;
   endtask

   task automatic test_ko_round();
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      n_total++; if ({state, timer} !== {3'd2, 8'd12}) $display("FAIL fight_dec got %0d/%0d want 2/12", state, timer); else n_pass++;
      left_health = 2'd0;
      step();
      left_health = 2'd3;
      n_total++; if (state !== 3'd3) $display("FAIL ko_state got %0d want 3", state); else n_pass++;
      n_total++; if ({right_wins, left_wins, round_num} !== {2'd1, 2'd0, 2'd1}) $display("FAIL ko_scores got %0d/%0d/%0d want 1/0/1", right_wins, left_wins, round_num); else n_pass++;
      n_total++; if (player_rst_n !== 1'b0) $display("FAIL ko_prn got %b want 0", player_rst_n); else n_pass++;
      n_total++; if ({right_player_input, left_player_input} !== 12'd0) $display("FAIL ko_gate got %h/%h want 0/0", right_player_input, left_player_input); else n_pass++;
      step();
      n_total++; if ({state, timer, player_rst_n} !== {3'd1, 8'd2, 1'b1}) $display("FAIL re_cd got %0d/%0d/%b want 1/2/1", state, timer, player_rst_n); else n_pass++;
      right_health = 2'd0;
      step(); step(); step();
      right_health = 2'd3;
      n_total++; if ({state, left_wins, round_num} !== {3'd2, 2'd0, 2'd1}) $display("FAIL health_ignored got %0d/%0d/%0d want 2/0/1", state, left_wins, round_num); else n_pass++;
   endtask

   task automatic test_match_right();
      left_health = 2'd0;
      step();
      left_health = 2'd3;
      n_total++; if ({state, right_wins} !== {3'd3, 2'd2}) $display("FAIL ko2 got %0d/%0d want 3/2", state, right_wins); else n_pass++;
      step();
      n_total++; if (state !== 3'd4) $display("FAIL me_state got %0d want 4", state); else n_pass++;
      n_total++; if ({winner, match_over} !== {2'b01, 1'b1}) $display("FAIL me_winner got %b/%b want 01/1", winner, match_over); else n_pass++;
      n_total++; if ({round_num, player_rst_n} !== {2'd2, 1'b1}) $display("FAIL me_round got %0d/%b want 2/1", round_num, player_rst_n); else n_pass++;
      step();
      n_total++; if ({state, winner, right_wins} !== {3'd4, 2'b01, 2'd2}) $display("FAIL me_hold got %0d/%b/%0d want 4/01/2", state, winner, right_wins); else n_pass++;
   endtask

   task automatic test_draws();
      start = 1'b1;
      step();
      start = 1'b0;
      n_total++; if ({state, right_wins, round_num, winner} !== {3'd1, 2'd0, 2'd0, 2'd0}) $display("FAIL restart got %0d/%0d/%0d/%b want 1/0/0/00", state, right_wins, round_num, winner); else n_pass++;
      n_total++; if ({player_rst_n, match_over} !== 2'b00) $display("FAIL restart_prn got %b/%b want 0/0", player_rst_n, match_over); else n_pass++;
      for (int r = 0; r < 3; r++) begin
         step(); step(); step();
         for (int k = 0; k < 15; k++) step();
         n_total++; if ({state, timer} !== {3'd2, 8'd0}) $display("FAIL draw_t0 r%0d got %0d/%0d want 2/0", r, state, timer); else n_pass++;
         step();
         n_total++; if ({state, round_num, right_wins, left_wins} !== {3'd3, 2'(r + 1), 2'd0, 2'd0}) $display("FAIL draw_round r%0d got %0d/%0d/%0d/%0d want 3/%0d/0/0", r, state, round_num, right_wins, left_wins, r + 1); else n_pass++;
         step();
         if (r < 2) begin
            n_total++; if ({state, timer} !== {3'd1, 8'd2}) $display("FAIL draw_next r%0d got %0d/%0d want 1/2", r, state, timer); else n_pass++;
         end else begin
            n_total++; if ({state, winner, match_over} !== {3'd4, 2'b11, 1'b1}) $display("FAIL draw_match got %0d/%b/%b want 4/11/1", state, winner, match_over); else n_pass++;
         end
      end
   endtask

   task automatic test_timeout_and_double_ko();
      start = 1'b1;
      step();
      start = 1'b0;
      right_health = 2'd1; left_health = 2'd2;
      for (int k = 0; k < 19; k++) step();
      n_total++; if ({state, right_wins, left_wins, round_num} !== {3'd3, 2'd0, 2'd1, 2'd1}) $display("FAIL timeout got %0d/%0d/%0d/%0d want 3/0/1/1", state, right_wins, left_wins, round_num); else n_pass++;
      step(); step(); step(); step();
      right_health = 2'd0; left_health = 2'd0;
      step();
      n_total++; if ({state, right_wins, left_wins, round_num} !== {3'd3, 2'd0, 2'd1, 2'd2}) $display("FAIL double_ko got %0d/%0d/%0d/%0d want 3/0/1/2", state, right_wins, left_wins, round_num); else n_pass++;
      left_health = 2'd3;
      step(); step(); step(); step();
      step();
      n_total++; if ({state, left_wins, round_num} !== {3'd3, 2'd2, 2'd3}) $display("FAIL left_ko got %0d/%0d/%0d want 3/2/3", state, left_wins, round_num); else n_pass++;
      step();
      n_total++; if ({state, winner} !== {3'd4, 2'b10}) $display("FAIL left_match got %0d/%b want 4/10", state, winner); else n_pass++;
      right_health = 2'd3;
   endtask

   task automatic test_async_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      left_health = 2'd0;
      step();
      left_health = 2'd3;
      step(); step(); step(); step();
      right_raw_input = 6'h3F; left_raw_input = 6'h3F;
      step();
      n_total++; if ({state, timer, right_wins, right_player_input} !== {3'd2, 8'd14, 2'd1, 6'h3F}) $display("FAIL pre_abort got %0d/%0d/%0d/%h want 2/14/1/3f", state, timer, right_wins, right_player_input); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if (state !== 3'd0) $display("FAIL abort_state got %0d want 0", state); else n_pass++;
      n_total++; if ({right_player_input, left_player_input} !== 12'd0) $display("FAIL abort_gate got %h/%h want 0/0", right_player_input, left_player_input); else n_pass++;
      n_total++; if ({right_wins, left_wins, round_num, timer, player_rst_n} !== 15'd0) $display("FAIL abort_scores got %0d/%0d/%0d/%0d/%b want 0", right_wins, left_wins, round_num, timer, player_rst_n); else n_pass++;
      step();
      rst_n = 1'b1;
      step();
      n_total++; if ({state, right_player_input} !== {3'd0, 6'h00}) $display("FAIL post_abort got %0d/%h want 0/00", state, right_player_input); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_ko_round();
      test_match_right();
      test_draws();
      test_timeout_and_double_ko();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
